// File: rtl/accelerator_pkg.sv
// Shared types, constants and helpers for the vector load/store unit.
package accelerator_pkg;

  typedef enum logic [1:0] {
    VLSU_IDLE  = 2'd0,
    VLSU_ISSUE = 2'd1,
    VLSU_DRAIN = 2'd2,
    VLSU_DONE  = 2'd3
  } vlsu_state_t;

  localparam int VLSU_WORD_BYTES = 4;

  // Byte mask of the final word; a zero remainder means the word is full.
  function automatic logic [3:0] vlsu_tail_mask(input logic [1:0] vl_lo);
    logic [3:0] mask;
    case (vl_lo)
      2'd1:    mask = 4'b0001;
      2'd2:    mask = 4'b0011;
      2'd3:    mask = 4'b0111;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/vlsu_txn_counter.sv
// Granted-but-unanswered memory transaction counter; saturates at MAX_OUTSTANDING.
module vlsu_txn_counter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic full
);

  logic [1:0] count_q;
  logic [1:0] count_d;

  // Grant and response in the same cycle leave the count unchanged.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 2'd0;
    end else if (inc && !dec && !full) begin
      count_d = count_q + 2'd1;
    end else if (dec && !inc && (count_q != 2'd0)) begin
      count_d = count_q - 2'd1;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign full = (int'(count_q) >= MAX_OUTSTANDING);

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store unit: moves vl byte elements between an OBI data port and vector registers.
// Optional build macro VLSU_BUS_ERR_EN adds error-response handling (data_err_i / bus_err).
module vector_lsu
  import accelerator_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int VREG_ADDR_W     = 5
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   start,
  input  logic                   is_store,
  input  logic [31:0]            base_addr,
  input  logic [4:0]             vl,
  input  logic [VREG_ADDR_W-1:0] vreg_base,
  output logic                   busy,
  output logic                   done,
  output logic                   misaligned_err,
  output logic                   data_req_o,
  input  logic                   data_gnt_i,
  output logic [31:0]            data_addr_o,
  output logic                   data_we_o,
  output logic [3:0]             data_be_o,
  output logic [31:0]            data_wdata_o,
  input  logic                   data_rvalid_i,
  input  logic [31:0]            data_rdata_i,
`ifdef VLSU_BUS_ERR_EN
  input  logic                   data_err_i,
  output logic                   bus_err,
`endif
  output logic                   vreg_wr_en,
  output logic [VREG_ADDR_W-1:0] vreg_wr_addr,
  output logic [31:0]            vreg_wr_data,
  output logic [3:0]             vreg_wr_be,
  output logic [VREG_ADDR_W-1:0] vreg_rd_addr,
  input  logic [31:0]            vreg_rd_data
);

  vlsu_state_t            state_q, state_d;
  logic                   is_store_q, is_store_d;
  logic [31:0]            base_q, base_d;
  logic [4:0]             vl_q, vl_d;
  logic [VREG_ADDR_W-1:0] vreg_base_q, vreg_base_d;
  logic                   misaligned_q, misaligned_d;
  logic [3:0]             issued_q, issued_d;
  logic [3:0]             received_q, received_d;

  logic [5:0] vl_plus3_s;
  logic [3:0] nwords_s;
  logic [3:0] issue_be_s;
  logic [3:0] resp_be_s;
  logic       active_s, in_issue_s, capture_s;
  logic       base_req_s, req_s, gnt_fire_s, resp_s, wr_ok_s;
  logic       full_s, finish_s, issue_over_s;

  assign vl_plus3_s = {1'b0, vl_q} + 6'd3;
  assign nwords_s   = vl_plus3_s[5:2];
  assign active_s   = (state_q == VLSU_ISSUE) || (state_q == VLSU_DRAIN);
  assign in_issue_s = (state_q == VLSU_ISSUE);
  assign capture_s  = (state_q == VLSU_IDLE) && start;
  assign base_req_s = in_issue_s && !misaligned_q && (issued_q < nwords_s) && !full_s;
  assign gnt_fire_s = req_s && data_gnt_i;
  assign resp_s     = active_s && data_rvalid_i;
  assign issue_be_s = (issued_q == nwords_s - 4'd1) ? vlsu_tail_mask(vl_q[1:0]) : 4'b1111;
  assign resp_be_s  = (received_q == nwords_s - 4'd1) ? vlsu_tail_mask(vl_q[1:0]) : 4'b1111;

`ifdef VLSU_BUS_ERR_EN
  logic err_q, err_d;
  logic hold_q, hold_d;

  // After an error response no new request starts, but an ungranted one stays up.
  assign req_s        = base_req_s && (!err_q || hold_q);
  assign wr_ok_s      = !data_err_i && !err_q;
  assign finish_s     = (received_d == nwords_s) || (err_d && (received_d == issued_d) && !hold_d);
  assign issue_over_s = (issued_d == nwords_s) || (err_d && !hold_d);

  always_comb begin
    hold_d = req_s && !data_gnt_i;
    if (capture_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q || (resp_s && data_err_i);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      err_q  <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      hold_q <= hold_d;
    end
  end

  assign bus_err = (state_q == VLSU_DONE) && err_q;
`else
  assign req_s        = base_req_s;
  assign wr_ok_s      = 1'b1;
  assign finish_s     = (received_d == nwords_s);
  assign issue_over_s = (issued_d == nwords_s);
`endif

  vlsu_txn_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_txn_counter (
    .clk     (clk),
    .n_reset (n_reset),
    .clr     (capture_s),
    .inc     (gnt_fire_s),
    .dec     (resp_s),
    .full    (full_s)
  );

  // Operand capture on start and issue/response bookkeeping.
  always_comb begin
    is_store_d   = is_store_q;
    base_d       = base_q;
    vl_d         = vl_q;
    vreg_base_d  = vreg_base_q;
    misaligned_d = misaligned_q;
    issued_d     = issued_q;
    received_d   = received_q;
    if (capture_s) begin
      is_store_d   = is_store;
      base_d       = base_addr;
      vl_d         = vl;
      vreg_base_d  = vreg_base;
      misaligned_d = (base_addr[1:0] != 2'b00);
      issued_d     = 4'd0;
      received_d   = 4'd0;
    end else if (active_s) begin
      issued_d   = issued_q + {3'd0, gnt_fire_s};
      received_d = received_q + {3'd0, resp_s};
    end else begin
      issued_d   = issued_q;
      received_d = received_q;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      is_store_q   <= 1'b0;
      base_q       <= 32'd0;
      vl_q         <= 5'd0;
      vreg_base_q  <= '0;
      misaligned_q <= 1'b0;
      issued_q     <= 4'd0;
      received_q   <= 4'd0;
    end else begin
      is_store_q   <= is_store_d;
      base_q       <= base_d;
      vl_q         <= vl_d;
      vreg_base_q  <= vreg_base_d;
      misaligned_q <= misaligned_d;
      issued_q     <= issued_d;
      received_q   <= received_d;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= VLSU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Empty and misaligned transfers are decided from captured operands in the first ISSUE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      VLSU_IDLE: begin
        if (start) begin
          state_d = VLSU_ISSUE;
        end else begin
          state_d = VLSU_IDLE;
        end
      end
      VLSU_ISSUE: begin
        if (misaligned_q || (nwords_s == 4'd0) || finish_s) begin
          state_d = VLSU_DONE;
        end else if (issue_over_s) begin
          state_d = VLSU_DRAIN;
        end else begin
          state_d = VLSU_ISSUE;
        end
      end
      VLSU_DRAIN: begin
        if (finish_s) begin
          state_d = VLSU_DONE;
        end else begin
          state_d = VLSU_DRAIN;
        end
      end
      VLSU_DONE: state_d = VLSU_IDLE;
      default:   state_d = VLSU_IDLE;
    endcase
  end

  // Bus and register-port outputs; everything is quiet outside the active states.
  always_comb begin
    busy           = (state_q != VLSU_IDLE);
    done           = (state_q == VLSU_DONE);
    misaligned_err = (state_q == VLSU_DONE) && misaligned_q;
    data_req_o     = req_s;
    data_addr_o    = 32'd0;
    data_we_o      = 1'b0;
    data_be_o      = 4'b0000;
    data_wdata_o   = 32'd0;
    vreg_rd_addr   = vreg_base_q + VREG_ADDR_W'(issued_q);
    vreg_wr_en     = 1'b0;
    vreg_wr_addr   = vreg_base_q + VREG_ADDR_W'(received_q);
    vreg_wr_data   = 32'd0;
    vreg_wr_be     = 4'b0000;
    if (in_issue_s) begin
      data_addr_o  = base_q + 32'(issued_q) * 32'(VLSU_WORD_BYTES);
      data_we_o    = is_store_q;
      data_be_o    = issue_be_s;
      data_wdata_o = is_store_q ? vreg_rd_data : 32'd0;
    end else begin
      data_addr_o  = 32'd0;
    end
    if (resp_s && !is_store_q && wr_ok_s) begin
      vreg_wr_en   = 1'b1;
      vreg_wr_data = data_rdata_i;
      vreg_wr_be   = resp_be_s;
    end else begin
      vreg_wr_en   = 1'b0;
    end
  end

endmodule

// File: tb/tb_vector_lsu.sv
// Directed, table-driven bench for vector_lsu with an OBI memory model and a vector register file model.
module tb_vector_lsu;

  logic        clk = 1'b0;
  logic        n_reset, start, is_store;
  logic [31:0] base_addr;
  logic [4:0]  vl, vreg_base;
  logic        busy, done, misaligned_err;
  logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]  data_be_o;
  logic        vreg_wr_en;
  logic [4:0]  vreg_wr_addr, vreg_rd_addr;
  logic [31:0] vreg_wr_data, vreg_rd_data;
  logic [3:0]  vreg_wr_be;
`ifdef VLSU_BUS_ERR_EN
  logic        data_err_i, bus_err;
`endif

  vector_lsu #(.MAX_OUTSTANDING(2), .VREG_ADDR_W(5)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .is_store(is_store),
    .base_addr(base_addr), .vl(vl), .vreg_base(vreg_base),
    .busy(busy), .done(done), .misaligned_err(misaligned_err),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
`ifdef VLSU_BUS_ERR_EN
    .data_err_i(data_err_i), .bus_err(bus_err),
`endif
    .vreg_wr_en(vreg_wr_en), .vreg_wr_addr(vreg_wr_addr), .vreg_wr_data(vreg_wr_data),
    .vreg_wr_be(vreg_wr_be), .vreg_rd_addr(vreg_rd_addr), .vreg_rd_data(vreg_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int gnt_dly = 0;
  int rv_dly = 1;
  int err_beat = -1;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] init_val(input int i);
    if (i == 2) return 32'hAABBCCDD;
    else if (i == 3) return 32'h11223344;
    else return 32'h5A5A0000 + 32'(i);
  endfunction

  // Byte b of word idx is live when its element index is below vl.
  function automatic logic [3:0] exp_be(input int idx, input int vlen);
    logic [3:0] m;
    m = 4'b0000;
    for (int b = 0; b < 4; b++) if (idx * 4 + b < vlen) m[b] = 1'b1;
    return m;
  endfunction

  // Vector register file model.
  logic [31:0] regs [32];
  assign vreg_rd_data = regs[vreg_rd_addr];
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
    end else if (vreg_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (vreg_wr_be[b]) regs[vreg_wr_addr][8*b +: 8] <= vreg_wr_data[8*b +: 8];
    end
  end

  // OBI memory responder: grant after gnt_dly wait cycles, in-order response rv_dly cycles later.
  typedef struct { int due; logic [31:0] addr; } rsp_t;
  rsp_t rq[$];
  int wait_cnt = 0;
  int resp_idx = 0;
  initial begin
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'd0;
`ifdef VLSU_BUS_ERR_EN
    data_err_i = 1'b0;
`endif
    forever begin
      @(posedge clk); #1;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'd0;
`ifdef VLSU_BUS_ERR_EN
      data_err_i = 1'b0;
`endif
      if (!busy) resp_idx = 0;
      if (!n_reset) begin
        rq.delete(); wait_cnt = 0; resp_idx = 0;
      end else begin
        if (data_req_o) begin
          if (wait_cnt >= gnt_dly) begin
            data_gnt_i = 1'b1; wait_cnt = 0;
            rq.push_back('{due: cyc + rv_dly, addr: data_addr_o});
          end else wait_cnt++;
        end else wait_cnt = 0;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
          rsp_t r;
          r = rq.pop_front();
          data_rvalid_i = 1'b1;
          data_rdata_i  = pat(r.addr);
`ifdef VLSU_BUS_ERR_EN
          data_err_i = (resp_idx == err_beat);
`endif
          resp_idx++;
        end
      end
    end
  end

  // Monitor: logs transactions and register writes of the current operation.
  logic [31:0] tx_addr [16];
  logic [31:0] tx_wdata [16];
  logic        tx_we [16];
  logic [3:0]  tx_be [16];
  logic [4:0]  wr_addr [16];
  logic [31:0] wr_data [16];
  logic [3:0]  wr_be [16];
  int n_txn = 0, n_wr = 0, done_cnt = 0, grants = 0, resps = 0, max_out = 0;
  int start_cyc = 0, done_cyc = -1;
  logic mis_at_done = 1'b0, berr_at_done = 1'b0;
  always @(negedge clk) begin
    if (start && !busy && n_reset) begin
      n_txn = 0; n_wr = 0; done_cnt = 0; grants = 0; resps = 0; max_out = 0;
      start_cyc = cyc; done_cyc = -1; mis_at_done = 1'b0; berr_at_done = 1'b0;
    end
    if (data_req_o && data_gnt_i) begin
      if (n_txn < 16) begin
        tx_addr[n_txn] = data_addr_o; tx_wdata[n_txn] = data_wdata_o;
        tx_we[n_txn] = data_we_o; tx_be[n_txn] = data_be_o;
      end
      n_txn++; grants++;
      if (grants - resps > max_out) max_out = grants - resps;
    end
    if (data_rvalid_i) resps++;
    if (vreg_wr_en) begin
      if (n_wr < 16) begin
        wr_addr[n_wr] = vreg_wr_addr; wr_data[n_wr] = vreg_wr_data; wr_be[n_wr] = vreg_wr_be;
      end
      n_wr++;
    end
    if (done) begin
      done_cnt++; done_cyc = cyc; mis_at_done = misaligned_err;
`ifdef VLSU_BUS_ERR_EN
      berr_at_done = bus_err;
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        is_store;
    logic [31:0] base;
    logic [4:0]  vl;
    logic [4:0]  vb;
    int gnt_dly; int rv_dly; int exp_lat; int exp_reqs; int exp_wrs;
    logic        exp_mis;
  } vec_t;

  task automatic launch(input vec_t v);
    gnt_dly = v.gnt_dly; rv_dly = v.rv_dly;
    tick();
    is_store = v.is_store; base_addr = v.base; vl = v.vl; vreg_base = v.vb; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 400 && done_cnt == 0; k++) tick();
    chk({name, "_done_seen"}, 32'(done_cnt), 32'd1);
    tick(); tick();
  endtask

  task automatic check_vec(input string name, input vec_t v);
    int nt, nw;
    if (v.exp_lat >= 0) chk({name, "_latency"}, 32'(done_cyc - start_cyc), 32'(v.exp_lat));
    chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({name, "_reqs"}, 32'(n_txn), 32'(v.exp_reqs));
    chk({name, "_wrs"}, 32'(n_wr), 32'(v.exp_wrs));
    chk({name, "_mis"}, 32'(mis_at_done), 32'(v.exp_mis));
    chk({name, "_max_out_le2"}, 32'(max_out <= 2), 32'd1);
`ifdef VLSU_BUS_ERR_EN
    chk({name, "_bus_err"}, 32'(berr_at_done), 32'd0);
`endif
    nt = (n_txn < 16) ? n_txn : 16;
    nw = (n_wr < 16) ? n_wr : 16;
    for (int i = 0; i < nt; i++) begin
      chk($sformatf("%s_addr%0d", name, i), tx_addr[i], v.base + 32'(4 * i));
      chk($sformatf("%s_we%0d", name, i), 32'(tx_we[i]), 32'(v.is_store));
      chk($sformatf("%s_be%0d", name, i), 32'(tx_be[i]), 32'(exp_be(i, int'(v.vl))));
      if (v.is_store)
        chk($sformatf("%s_wdata%0d", name, i), tx_wdata[i], regs[(int'(v.vb) + i) % 32]);
    end
    for (int i = 0; i < nw; i++) begin
      chk($sformatf("%s_wraddr%0d", name, i), 32'(wr_addr[i]), 32'((int'(v.vb) + i) % 32));
      chk($sformatf("%s_wrdata%0d", name, i), wr_data[i], pat(v.base + 32'(4 * i)));
      chk($sformatf("%s_wrbe%0d", name, i), 32'(wr_be[i]), 32'(exp_be(i, int'(v.vl))));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    vec_t v;
    int w0;
    vecs[0] = '{is_store: 1'b0, base: 32'h100, vl: 5'd7,  vb: 5'd4,  gnt_dly: 0, rv_dly: 1,
                exp_lat: 4,  exp_reqs: 2, exp_wrs: 2, exp_mis: 1'b0};
    vecs[1] = '{is_store: 1'b1, base: 32'h200, vl: 5'd8,  vb: 5'd2,  gnt_dly: 0, rv_dly: 1,
                exp_lat: 4,  exp_reqs: 2, exp_wrs: 0, exp_mis: 1'b0};
    vecs[2] = '{is_store: 1'b0, base: 32'h300, vl: 5'd31, vb: 5'd28, gnt_dly: 2, rv_dly: 3,
                exp_lat: -1, exp_reqs: 8, exp_wrs: 8, exp_mis: 1'b0};
    vecs[3] = '{is_store: 1'b0, base: 32'h100, vl: 5'd0,  vb: 5'd4,  gnt_dly: 0, rv_dly: 1,
                exp_lat: 2,  exp_reqs: 0, exp_wrs: 0, exp_mis: 1'b0};
    vecs[4] = '{is_store: 1'b0, base: 32'h102, vl: 5'd7,  vb: 5'd4,  gnt_dly: 0, rv_dly: 1,
                exp_lat: 2,  exp_reqs: 0, exp_wrs: 0, exp_mis: 1'b1};
    vecs[5] = '{is_store: 1'b1, base: 32'h400, vl: 5'd5,  vb: 5'd30, gnt_dly: 1, rv_dly: 2,
                exp_lat: -1, exp_reqs: 2, exp_wrs: 0, exp_mis: 1'b0};

    n_reset = 1'b0; start = 1'b0; is_store = 1'b0; base_addr = 32'd0; vl = 5'd0; vreg_base = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(data_req_o), 32'd0);
    chk("rst_addr", data_addr_o, 32'd0);
    chk("rst_be", 32'(data_be_o), 32'd0);
    chk("rst_wr_en", 32'(vreg_wr_en), 32'd0);
    chk("rst_mis", 32'(misaligned_err), 32'd0);
    n_reset = 1'b1;

    for (int n = 0; n < 6; n++) begin
      launch(vecs[n]);
      wait_done($sformatf("vec%0d", n));
      check_vec($sformatf("vec%0d", n), vecs[n]);
    end

    // Start while busy and start in the DONE cycle are both ignored.
    launch(vecs[0]);
    tick();
    is_store = 1'b1; base_addr = 32'h500; vl = 5'd20; vreg_base = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("ign_done_now", 32'(done), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_busy_after_done", 32'(busy), 32'd0);
    repeat (4) tick();
    chk("ign_busy_later", 32'(busy), 32'd0);
    chk("ign_done_pulses", 32'(done_cnt), 32'd1);
    chk("ign_latency", 32'(done_cyc - start_cyc), 32'd4);
    chk("ign_reqs", 32'(n_txn), 32'd2);
    chk("ign_addr1", tx_addr[1], 32'h104);
    chk("ign_we0", 32'(tx_we[0]), 32'd0);
    launch(vecs[0]);
    wait_done("fresh");
    check_vec("fresh", vecs[0]);

    // Reset in the middle of a slow load.
    v = vecs[2];
    v.vb = 5'd10;
    launch(v);
    repeat (5) tick();
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req", 32'(data_req_o), 32'd0);
    w0 = n_wr;
    @(negedge clk);
    n_reset = 1'b1;
    repeat (10) tick();
    chk("midrst_no_writes", 32'(n_wr), 32'(w0));
    chk("midrst_idle", 32'(busy), 32'd0);
    launch(vecs[1]);
    wait_done("post_rst");
    check_vec("post_rst", vecs[1]);

`ifdef VLSU_BUS_ERR_EN
    err_beat = 1;
    v = '{is_store: 1'b0, base: 32'h600, vl: 5'd12, vb: 5'd8, gnt_dly: 0, rv_dly: 1,
          exp_lat: -1, exp_reqs: 3, exp_wrs: 1, exp_mis: 1'b0};
    launch(v);
    wait_done("berr");
    err_beat = -1;
    chk("berr_flag", 32'(berr_at_done), 32'd1);
    chk("berr_reqs", 32'(n_txn), 32'd3);
    chk("berr_wrs", 32'(n_wr), 32'd1);
    chk("berr_wraddr0", 32'(wr_addr[0]), 32'd8);
    chk("berr_wrdata0", wr_data[0], pat(32'h600));
    chk("berr_drained", 32'(resps), 32'd3);
    chk("berr_mis", 32'(mis_at_done), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
